// File: rtl/dmem_bist_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_bist_master : write/read-back self-test of the 16-word data memory.   |
// | Optional DMEM_BIST_MARCH_INV_EN adds inverted write-down / read-up passes. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_bist_master #(
   parameter int unsigned       ADDR_W = 6,
   parameter int unsigned       DATA_W = 32,
   parameter int unsigned       WORDS  = 16,
   parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wd,
   input  logic [DATA_W-1:0]       mem_rd,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [$clog2(WORDS):0]  err_cnt,
   output logic [ADDR_W-1:0]       fail_addr,
   output logic [DATA_W-1:0]       fail_data
);

   localparam int unsigned      IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned      ERR_W    = $clog2(WORDS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(WORDS);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WRITE     = 3'd1;
   localparam logic [2:0] ST_READ      = 3'd2;
   localparam logic [2:0] ST_DONE      = 3'd3;
`ifdef DMEM_BIST_MARCH_INV_EN
   localparam logic [2:0] ST_WRITE_INV = 3'd4;
   localparam logic [2:0] ST_READ_INV  = 3'd5;
`endif

   logic [2:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;

   logic [ADDR_W-1:0] idx_addr;
   logic [DATA_W-1:0] pattern;
   logic [DATA_W-1:0] exp_data;
   logic              chk;

   assign idx_addr = ADDR_W'(idx_q) << 2;
   assign pattern  = SEED + DATA_W'(idx_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         err_q       <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_d       = err_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      chk         = 1'b0;
      exp_data    = pattern;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_WRITE;
               idx_d       = '0;
               err_d       = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         ST_WRITE: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_READ;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_READ: begin
            chk = 1'b1;
            if (idx_q == LAST_IDX) begin
`ifdef DMEM_BIST_MARCH_INV_EN
               state_d = ST_WRITE_INV;
               idx_d   = LAST_IDX;
`else
               state_d = ST_DONE;
               idx_d   = '0;
`endif
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
`ifdef DMEM_BIST_MARCH_INV_EN
         ST_WRITE_INV: begin
            if (idx_q == '0) begin
               state_d = ST_READ_INV;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         ST_READ_INV: begin
            chk      = 1'b1;
            exp_data = ~pattern;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
      // Only the first mismatch is captured; the count saturates at WORDS.
      if (chk && (mem_rd != exp_data)) begin
         if (err_q == '0) begin
            fail_addr_d = idx_addr;
            fail_data_d = mem_rd;
         end
         if (err_q < ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
         end
      end
   end

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      busy     = 1'b0;
      done     = 1'b0;
      pass     = 1'b0;
      case (state_q)
         ST_WRITE: begin
            mem_we   = 1'b1;
            mem_addr = idx_addr;
            mem_wd   = pattern;
            busy     = 1'b1;
         end
         ST_READ: begin
            mem_addr = idx_addr;
            busy     = 1'b1;
         end
`ifdef DMEM_BIST_MARCH_INV_EN
         ST_WRITE_INV: begin
            mem_we   = 1'b1;
            mem_addr = idx_addr;
            mem_wd   = ~pattern;
            busy     = 1'b1;
         end
         ST_READ_INV: begin
            mem_addr = idx_addr;
            busy     = 1'b1;
         end
`endif
         ST_DONE: begin
            done = 1'b1;
            pass = (err_q == '0);
         end
         default: ;
      endcase
   end

   assign err_cnt   = err_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;

endmodule
`default_nettype wire
